// File: rtl/cpa16_serial_addsub.sv
// cpa16_serial_addsub: digit-serial adder/subtractor. One DIGIT-wide
// carry-propagate slice is reused for WIDTH/DIGIT cycles. The carry between
// digits is held in a flop. Subtraction is done as a + ~b + ~c_in.
//
// Handshake: start/sub/a/b/c_in are sampled on a rising edge only while the
// block is in IDLE or DONE; start is ignored in RUN. busy is high for the N
// cycles of RUN. done is a one-cycle pulse in DONE, and it coincides with
// the update of s/c_out/ovf. busy and done are never high together.
// WIDTH must be a multiple of DIGIT, and WIDTH/DIGIT must be at least 2.
module cpa16_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, p_q;
    logic [WIDTH-1:0] s_q;
    logic             c_out_q, ovf_q;

    logic             load;
    logic             last;
    logic [DIGIT:0]   slice;
    logic             slice_cout;
    logic             msb_cin;

    // A new operation is taken only outside RUN.
    assign load = start && (state_q != RUN);
    assign last = (state_q == RUN) && (cnt_q == CW'(N - 1));

    // The shared slice: low digit of A plus low digit of B plus the carry flop.
    assign slice      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, carry_q};
    assign slice_cout = slice[DIGIT];
    // The carry into the slice MSB is recovered from that bit's sum, a and b.
    assign msb_cin    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load operands, shift one digit per RUN cycle, and commit the results on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= c_in ^ sub;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            p_q     <= {slice[DIGIT-1:0], p_q[WIDTH-1:DIGIT]};
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                s_q     <= {slice[DIGIT-1:0], p_q[WIDTH-1:DIGIT]};
                c_out_q <= slice_cout;
                ovf_q   <= msb_cin ^ slice_cout;
            end
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign s         = s_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule
